// File: rtl/mem_rd_arbiter.sv
// Two-requester (I-cache / D-cache) read arbiter onto a single AXI AR/R channel.
// One outstanding burst at a time; round-robin on ties; sticky error on protocol/response faults.
module mem_rd_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    // I-cache requester
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [7:0]        i_len,
    output logic              i_ack,
    output logic              i_rvalid,
    output logic              i_rlast,
    // D-cache requester
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [7:0]        d_len,
    output logic              d_ack,
    output logic              d_rvalid,
    output logic              d_rlast,
    output logic [DATA_W-1:0] rdata_o,
    // AXI AR channel
    output logic              arvalid,
    input  logic              arready,
    output logic [ADDR_W-1:0] araddr,
    output logic [7:0]        arlen,
    // AXI R channel
    input  logic              rvalid,
    output logic              rready,
    input  logic [DATA_W-1:0] rdata,
    input  logic              rlast,
    input  logic [1:0]        rresp,
    // status
    output logic              busy,
    output logic              err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_AR,
        ST_R
    } state_e;

    state_e            state_q, state_d;
    logic              owner_q, owner_d;          // 1 = D-cache owns the burst
    logic              last_grant_q, last_grant_d; // 1 = D-cache was granted last
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        len_q, len_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;

    logic              ar_hs;
    logic              beat;
    logic              cnt_end;
    logic              final_beat;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        err_d        = err_q;

        ar_hs      = (state_q == ST_AR) && arready;
        beat       = (state_q == ST_R) && rvalid;
        cnt_end    = (cnt_q == len_q);
        // A beat on counter == len closes the burst even without rlast, so a faulty slave cannot hang us.
        final_beat = beat && (rlast || cnt_end);

        unique case (state_q)
            ST_IDLE: begin
                if (i_req || d_req) begin
                    owner_d = (i_req && d_req) ? ~last_grant_q : d_req;
                    addr_d  = owner_d ? d_addr : i_addr;
                    len_d   = owner_d ? d_len  : i_len;
                    state_d = ST_AR;
                end
            end
            ST_AR: begin
                if (arready) begin
                    last_grant_d = owner_q;
                    cnt_d        = '0;
                    state_d      = ST_R;
                end
            end
            ST_R: begin
                if (rvalid) begin
                    cnt_d = cnt_q + 8'd1;
                    if ((rresp != 2'b00) || (rlast != cnt_end)) begin
                        err_d = 1'b1;
                    end
                    if (rlast || cnt_end) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b0;
            addr_q       <= '0;
            len_q        <= '0;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of its peers.
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
        end
    end

    assign arvalid  = (state_q == ST_AR);
    assign araddr   = addr_q;
    assign arlen    = len_q;
    assign i_ack    = ar_hs && !owner_q;
    assign d_ack    = ar_hs &&  owner_q;

    assign rready   = (state_q == ST_R);
    assign i_rvalid = beat && !owner_q;
    assign d_rvalid = beat &&  owner_q;
    assign i_rlast  = final_beat && !owner_q;
    assign d_rlast  = final_beat &&  owner_q;
    assign rdata_o  = rdata;

    assign busy     = busy_q;
    assign err      = err_q;

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Self-checking bench for mem_rd_arbiter: directed scenarios then randomized bursts,
// checked against a transaction-level model of grants, beats and the sticky error.
module tb_mem_rd_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              resetn;
    logic              i_req, d_req;
    logic [ADDR_W-1:0] i_addr, d_addr;
    logic [7:0]        i_len, d_len;
    logic              i_ack, d_ack, i_rvalid, d_rvalid, i_rlast, d_rlast;
    logic [DATA_W-1:0] rdata_o;
    logic              arvalid, arready;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic              rvalid, rready, rlast;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              busy, err;

    always #5 clk = ~clk;

    mem_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .resetn(resetn),
        .i_req(i_req), .i_addr(i_addr), .i_len(i_len),
        .i_ack(i_ack), .i_rvalid(i_rvalid), .i_rlast(i_rlast),
        .d_req(d_req), .d_addr(d_addr), .d_len(d_len),
        .d_ack(d_ack), .d_rvalid(d_rvalid), .d_rlast(d_rlast),
        .rdata_o(rdata_o),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rlast(rlast), .rresp(rresp),
        .busy(busy), .err(err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // transaction-level model state
    bit model_lg;   // requester granted last: 0 = I, 1 = D
    bit model_err;
    bit pend_i, pend_d;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // advance to the drive point, 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic raise_req(input bit who_d, input int len);
        int lv;
        lv = (len < 0) ? int'($urandom_range(0, 7)) : len;
        if (who_d) begin
            d_addr = $urandom;
            d_len  = 8'(lv);
            d_req  = 1'b1;
            pend_d = 1'b1;
        end else begin
            i_addr = $urandom;
            i_len  = 8'(lv);
            i_req  = 1'b1;
            pend_i = 1'b1;
        end
    endtask

    task automatic do_reset();
        resetn  = 1'b0;
        i_req   = 1'b0;  d_req  = 1'b0;
        i_addr  = '0;    d_addr = '0;
        i_len   = '0;    d_len  = '0;
        arready = 1'b0;
        rvalid  = 1'b0;  rlast  = 1'b0;
        rdata   = '0;    rresp  = 2'b00;
        model_lg = 1'b0; model_err = 1'b0;
        pend_i   = 1'b0; pend_d    = 1'b0;
        #1;
        check("rst_busy",    64'(busy),    64'(0));
        check("rst_err",     64'(err),     64'(0));
        check("rst_arvalid", 64'(arvalid), 64'(0));
        check("rst_rready",  64'(rready),  64'(0));
        check("rst_acks",    64'({i_ack, d_ack}), 64'(0));
        step();
        step();
        resetn = 1'b1;
    endtask

    // Serve one burst for whoever the model says wins.
    // mode: 0 clean, 1 early rlast, 2 bad rresp on one beat, 3 rlast missing, 4 reset after first beat
    task automatic serve(input int ar_stall, input int mode, input int gap_min, input int gap_max,
                         input bit [1:0] raise_mask);
        bit                exp_d;
        bit                seen;
        logic [ADDR_W-1:0] ea;
        logic [7:0]        el;
        int                early, badbeat, endbeat, gap;
        bit                want_last;

        exp_d = (pend_i && pend_d) ? ~model_lg : pend_d;
        ea    = exp_d ? d_addr : i_addr;
        el    = exp_d ? d_len  : i_len;

        seen = 1'b0;
        for (int c = 0; c < 4 && !seen; c++) begin
            step();
            arready = (ar_stall == 0);
            #1;
            if (arvalid) seen = 1'b1;
        end
        if (!seen) begin
            check("ar_timeout", 64'(arvalid), 64'(1));
            return;
        end

        for (int c = 0; c <= ar_stall; c++) begin
            if (c > 0) begin
                step();
                arready = (c == ar_stall);
                #1;
            end
            check("arvalid", 64'(arvalid), 64'(1));
            check("araddr",  64'(araddr),  64'(ea));
            check("arlen",   64'(arlen),   64'(el));
            check("busy_ar", 64'(busy),    64'(1));
            check("i_ack",   64'(i_ack),   64'((c == ar_stall) && !exp_d));
            check("d_ack",   64'(d_ack),   64'((c == ar_stall) &&  exp_d));
        end
        model_lg = exp_d;

        step();
        arready = 1'b0;
        if (exp_d) begin d_req = 1'b0; pend_d = 1'b0; end
        else       begin i_req = 1'b0; pend_i = 1'b0; end
        if (raise_mask[0] && !pend_i) raise_req(1'b0, -1);
        if (raise_mask[1] && !pend_d) raise_req(1'b1, -1);

        early   = -1;
        badbeat = -1;
        if (mode == 1 && el > 0) early = int'($urandom_range(0, int'(el) - 1));
        if (mode == 2) badbeat = int'($urandom_range(0, int'(el)));
        endbeat = (early >= 0) ? early : int'(el);
        if (early >= 0 || badbeat >= 0 || mode == 3) model_err = 1'b1;

        for (int b = 0; b <= endbeat; b++) begin
            gap = int'($urandom_range(gap_min, gap_max));
            for (int g = 0; g < gap; g++) begin
                rvalid = 1'b0;
                #1;
                check("gap_rvalid", 64'({i_rvalid, d_rvalid}), 64'(0));
                check("gap_rready", 64'(rready), 64'(1));
                check("gap_busy",   64'(busy),   64'(1));
                step();
            end
            want_last = (b == endbeat);
            rvalid = 1'b1;
            rdata  = $urandom;
            rlast  = (mode == 3) ? 1'b0 : want_last;
            rresp  = (b == badbeat) ? 2'b10 : 2'b00;
            #1;
            check("rready",      64'(rready),   64'(1));
            check("rdata_o",     64'(rdata_o),  64'(rdata));
            check("i_rvalid",    64'(i_rvalid), 64'(!exp_d));
            check("d_rvalid",    64'(d_rvalid), 64'(exp_d));
            check("i_rlast",     64'(i_rlast),  64'(!exp_d && want_last));
            check("d_rlast",     64'(d_rlast),  64'(exp_d && want_last));
            if (mode == 4) begin
                step();
                check("err_pre_rst", 64'(err), 64'(model_err));
                resetn = 1'b0;
                rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
                i_req  = 1'b0; d_req = 1'b0;
                #1;
                check("midrst_busy",    64'(busy),    64'(0));
                check("midrst_rready",  64'(rready),  64'(0));
                check("midrst_err",     64'(err),     64'(0));
                check("midrst_arvalid", 64'(arvalid), 64'(0));
                check("midrst_rvalid",  64'({i_rvalid, d_rvalid}), 64'(0));
                model_lg = 1'b0; model_err = 1'b0;
                pend_i   = 1'b0; pend_d    = 1'b0;
                step();
                step();
                resetn = 1'b1;
                return;
            end
            if (!want_last) step();
        end

        step();
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
        #1;
        check("end_busy",    64'(busy),    64'(0));
        check("end_arvalid", 64'(arvalid), 64'(0));
        check("end_rready",  64'(rready),  64'(0));
        check("end_err",     64'(err),     64'(model_err));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int m;
        do_reset();

        // simultaneous requests after reset: D first, then I
        raise_req(1'b0, -1);
        raise_req(1'b1, -1);
        serve(0, 0, 0, 1, 2'b00);
        serve(0, 0, 0, 1, 2'b00);

        // D burst of 4 beats with 2-cycle gaps
        raise_req(1'b1, 3);
        serve(0, 0, 2, 2, 2'b00);

        // AR stalled 5 cycles
        raise_req(1'b0, -1);
        serve(5, 0, 0, 1, 2'b00);

        // I continuous, D once: I, D, I
        raise_req(1'b0, -1);
        serve(0, 0, 0, 1, 2'b11);
        serve(0, 0, 0, 1, 2'b01);
        serve(0, 0, 0, 1, 2'b00);

        // error cases: early rlast, bad rresp, missing rlast
        raise_req(1'b1, 3);
        serve(0, 1, 0, 1, 2'b00);
        raise_req(1'b0, 2);
        serve(0, 2, 0, 1, 2'b00);
        raise_req(1'b1, 2);
        serve(0, 3, 0, 1, 2'b00);

        // reset mid-burst, then a fresh tie served normally
        raise_req(1'b1, 3);
        serve(0, 4, 0, 1, 2'b00);
        raise_req(1'b0, -1);
        raise_req(1'b1, -1);
        serve(0, 0, 0, 1, 2'b00);
        serve(0, 0, 0, 1, 2'b00);

        // randomized traffic
        for (int it = 0; it < 150; it++) begin
            if ($urandom_range(0, 1) == 1 && !pend_i) raise_req(1'b0, -1);
            if ($urandom_range(0, 1) == 1 && !pend_d) raise_req(1'b1, -1);
            if (!pend_i && !pend_d) raise_req(1'($urandom_range(0, 1)), -1);
            m = int'($urandom_range(0, 9));
            serve(int'($urandom_range(0, 3)), (m < 7) ? 0 : m - 6, 0, 2,
                  2'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
